// File: rtl/demux_1_n_stream.sv
// Registered 1:N stream demultiplexer with per-channel valid/ready slots,
// broadcast mode and a saturating counter of words dropped for a bad select.
module demux_1_n_stream #(
    parameter int N_OUT  = 4,
    parameter int SEL_W  = 2,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_bcast,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic                    sel_err,
    output logic [CNT_W-1:0]        drop_cnt
);

    localparam logic [SEL_W:0] N_OUT_W = N_OUT[SEL_W:0];

    logic [N_OUT-1:0] free;
    logic [N_OUT-1:0] target;
    logic [N_OUT-1:0] load;
    logic             sel_ok;
    logic             accept;
    logic             drop;

    assign free   = ~out_valid | out_ready;
    assign sel_ok = {1'b0, in_sel} < N_OUT_W;

    // Broadcast targets every slot; otherwise a one-hot decode of in_sel.
    always_comb begin
        target = '0;
        for (int k = 0; k < N_OUT; k++) begin
            target[k] = in_bcast || (in_sel == SEL_W'(k));
        end
    end

    // A bad select is always accepted so the producer never stalls on it.
    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            if (in_bcast) begin
                in_ready = &free;
            end else if (!sel_ok) begin
                in_ready = 1'b1;
            end else begin
                in_ready = |(target & free);
            end
        end
    end

    assign accept = in_valid && in_ready;
    assign drop   = accept && !in_bcast && !sel_ok;
    assign load   = (accept && (in_bcast || sel_ok)) ? target : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_data  <= '0;
            sel_err   <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            sel_err <= drop;
            if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
            for (int k = 0; k < N_OUT; k++) begin
                if (load[k]) begin
                    out_valid[k]                  <= 1'b1;
                    out_data[k*DATA_W +: DATA_W] <= in_data;
                end else if (out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_1_n_stream.sv
// Bench for demux_1_n_stream: a 4-channel and a 3-channel (2-bit counter)
// instance share one stimulus stream and are checked against a slot model.
module tb_demux_1_n_stream;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_bcast;
    logic [3:0]  out_ready;

    logic        d4_ready, d3_ready;
    logic [3:0]  d4_valid;
    logic [2:0]  d3_valid;
    logic [31:0] d4_data;
    logic [23:0] d3_data;
    logic        d4_err, d3_err;
    logic [7:0]  d4_cnt;
    logic [1:0]  d3_cnt;

    int total = 0;
    int bad   = 0;

    demux_1_n_stream #(.N_OUT(4), .SEL_W(2), .DATA_W(8), .CNT_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d4_ready),
        .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
        .out_valid(d4_valid), .out_ready(out_ready), .out_data(d4_data),
        .sel_err(d4_err), .drop_cnt(d4_cnt)
    );

    demux_1_n_stream #(.N_OUT(3), .SEL_W(2), .DATA_W(8), .CNT_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d3_ready),
        .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
        .out_valid(d3_valid), .out_ready(out_ready[2:0]), .out_data(d3_data),
        .sel_err(d3_err), .drop_cnt(d3_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one occupancy flag and word per channel, per instance.
    logic       m_live = 1'b0;
    logic       m_valid [2][4];
    logic [7:0] m_data  [2][4];
    logic       m_err   [2];
    int         m_cnt   [2];

    function automatic int nout(input int i);
        return (i == 0) ? 4 : 3;
    endfunction

    function automatic int cmax(input int i);
        return (i == 0) ? 255 : 3;
    endfunction

    function automatic logic m_ready(input int i);
        if (!rst_n) return 1'b0;
        if (in_bcast) begin
            for (int ch = 0; ch < nout(i); ch++)
                if (m_valid[i][ch] && !out_ready[ch]) return 1'b0;
            return 1'b1;
        end
        if (int'(in_sel) >= nout(i)) return 1'b1;
        return !m_valid[i][in_sel] || out_ready[in_sel];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_live = 1'b1;
            for (int i = 0; i < 2; i++) begin
                m_err[i] = 1'b0;
                m_cnt[i] = 0;
                for (int ch = 0; ch < 4; ch++) begin
                    m_valid[i][ch] = 1'b0;
                    m_data[i][ch]  = 8'h00;
                end
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic acc;
                acc      = in_valid && m_ready(i);
                m_err[i] = acc && !in_bcast && (int'(in_sel) >= nout(i));
                if (m_err[i] && m_cnt[i] < cmax(i)) m_cnt[i]++;
                for (int ch = 0; ch < nout(i); ch++) begin
                    if (acc && (in_bcast || int'(in_sel) == ch)) begin
                        m_valid[i][ch] = 1'b1;
                        m_data[i][ch]  = in_data;
                    end else if (out_ready[ch]) begin
                        m_valid[i][ch] = 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            for (int i = 0; i < 2; i++) begin
                logic [3:0]  av, ev;
                logic [31:0] ad, ed;
                logic        ae, ar;
                logic [7:0]  ac;
                string       tag;
                if (i == 0) begin
                    av = d4_valid; ad = d4_data; ae = d4_err; ar = d4_ready; ac = d4_cnt; tag = "d4";
                end else begin
                    av = {1'b0, d3_valid}; ad = {8'h00, d3_data}; ae = d3_err;
                    ar = d3_ready; ac = {6'b0, d3_cnt}; tag = "d3";
                end
                ev = '0;
                ed = '0;
                for (int ch = 0; ch < nout(i); ch++) begin
                    ev[ch]        = m_valid[i][ch];
                    ed[ch*8 +: 8] = m_data[i][ch];
                end
                checkOutput({tag, " out_valid"}, 32'(av), 32'(ev));
                checkOutput({tag, " out_data"}, ad, ed);
                checkOutput({tag, " sel_err"}, 32'(ae), 32'(m_err[i]));
                checkOutput({tag, " drop_cnt"}, 32'(ac), 32'(m_cnt[i]));
                checkOutput({tag, " in_ready"}, 32'(ar), 32'(m_ready(i)));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d,
                                 input logic [1:0] s, input logic b);
        in_valid = v;
        in_data  = d;
        in_sel   = s;
        in_bcast = b;
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        out_ready = 4'h0;
        applyStimulus(1'b1, 8'h5A, 2'd0, 1'b0);

        // Reset held for two edges with a word offered.
        step();
        step();
        checkOutput("t1 in_ready", 32'(d4_ready), 32'h0);
        checkOutput("t1 out_valid", 32'(d4_valid), 32'h0);
        checkOutput("t1 drop_cnt", 32'(d4_cnt), 32'h0);
        checkOutput("t1 sel_err", 32'(d4_err), 32'h0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 8'h00, 2'd0, 1'b0);

        // Sweep all channels at full rate.
        out_ready = 4'hF;
        applyStimulus(1'b1, 8'hA0, 2'd0, 1'b0);
        step();
        applyStimulus(1'b1, 8'hA1, 2'd1, 1'b0);
        checkOutput("t2 valid0", 32'(d4_valid), 32'h1);
        checkOutput("t2 data0", 32'(d4_data[7:0]), 32'hA0);
        step();
        applyStimulus(1'b1, 8'hA2, 2'd2, 1'b0);
        checkOutput("t2 valid1", 32'(d4_valid), 32'h2);
        checkOutput("t2 data1", 32'(d4_data[15:8]), 32'hA1);
        step();
        applyStimulus(1'b1, 8'hA3, 2'd3, 1'b0);
        checkOutput("t2 valid2", 32'(d4_valid), 32'h4);
        checkOutput("t2 data2", 32'(d4_data[23:16]), 32'hA2);
        step();
        applyStimulus(1'b0, 8'h00, 2'd0, 1'b0);
        checkOutput("t2 valid3", 32'(d4_valid), 32'h8);
        checkOutput("t2 data3", 32'(d4_data[31:24]), 32'hA3);
        step();
        checkOutput("t2 drained", 32'(d4_valid), 32'h0);

        // Backpressure on channel 2 without blocking channel 1.
        out_ready = 4'b1011;
        applyStimulus(1'b1, 8'h55, 2'd2, 1'b0);
        step();
        applyStimulus(1'b1, 8'h66, 2'd2, 1'b0);
        checkOutput("t3 blocked ready", 32'(d4_ready), 32'h0);
        checkOutput("t3 held data", 32'(d4_data[23:16]), 32'h55);
        step();
        applyStimulus(1'b1, 8'h77, 2'd1, 1'b0);
        checkOutput("t3 other ready", 32'(d4_ready), 32'h1);
        checkOutput("t3 still held", 32'(d4_data[23:16]), 32'h55);
        step();
        checkOutput("t3 valid", 32'(d4_valid), 32'h6);
        checkOutput("t3 ch1 data", 32'(d4_data[15:8]), 32'h77);
        out_ready = 4'hF;
        applyStimulus(1'b1, 8'h66, 2'd2, 1'b0);
        checkOutput("t3 refill ready", 32'(d4_ready), 32'h1);
        step();
        checkOutput("t3 refill data", 32'(d4_data[23:16]), 32'h66);
        checkOutput("t3 refill valid", 32'(d4_valid), 32'h4);
        applyStimulus(1'b0, 8'h00, 2'd0, 1'b0);
        step();

        // Broadcast, then a broadcast stalled by a full channel 0.
        applyStimulus(1'b1, 8'hC3, 2'd0, 1'b1);
        checkOutput("t4 ready", 32'(d4_ready), 32'h1);
        step();
        checkOutput("t4 valid", 32'(d4_valid), 32'hF);
        checkOutput("t4 data", d4_data, 32'hC3C3C3C3);
        checkOutput("t4 d3 valid", 32'(d3_valid), 32'h7);
        out_ready = 4'b1110;
        applyStimulus(1'b1, 8'hD4, 2'd0, 1'b1);
        checkOutput("t4 stall ready", 32'(d4_ready), 32'h0);
        step();
        checkOutput("t4 stall valid", 32'(d4_valid), 32'h1);
        checkOutput("t4 stall data", 32'(d4_data[7:0]), 32'hC3);
        out_ready = 4'hF;
        applyStimulus(1'b1, 8'hD4, 2'd0, 1'b1);
        step();
        checkOutput("t4 resume data", d4_data, 32'hD4D4D4D4);
        applyStimulus(1'b0, 8'h00, 2'd0, 1'b0);
        step();

        // Invalid select on the 3-channel instance, then counter saturation.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        out_ready = 4'h0;
        applyStimulus(1'b1, 8'h11, 2'd0, 1'b0);
        step();
        applyStimulus(1'b1, 8'hEE, 2'd3, 1'b0);
        checkOutput("t5 ready", 32'(d3_ready), 32'h1);
        for (int n = 1; n <= 3; n++) begin
            step();
            checkOutput("t5 sel_err", 32'(d3_err), 32'h1);
            checkOutput("t5 drop_cnt", 32'(d3_cnt), 32'(n));
        end
        checkOutput("t5 valid", 32'(d3_valid), 32'h1);
        applyStimulus(1'b0, 8'h00, 2'd0, 1'b0);
        step();
        checkOutput("t5 err low", 32'(d3_err), 32'h0);
        applyStimulus(1'b1, 8'hEE, 2'd3, 1'b0);
        step();
        step();
        applyStimulus(1'b0, 8'h00, 2'd0, 1'b0);
        checkOutput("t5 saturated", 32'(d3_cnt), 32'h3);
        checkOutput("t5 d4 no drops", 32'(d4_cnt), 32'h0);
        checkOutput("t5 d4 valid", 32'(d4_valid), 32'h9);
        step();

        // Reset in the middle of held traffic.
        applyStimulus(1'b1, 8'h22, 2'd1, 1'b0);
        step();
        checkOutput("t6 held", 32'(d3_valid), 32'h3);
        rst_n = 1'b0;
        applyStimulus(1'b1, 8'h33, 2'd2, 1'b0);
        checkOutput("t6 ready low", 32'(d4_ready), 32'h0);
        step();
        checkOutput("t6 valid", 32'(d4_valid), 32'h0);
        checkOutput("t6 data", d4_data, 32'h0);
        checkOutput("t6 d3 data", 32'(d3_data), 32'h0);
        rst_n = 1'b1;
        out_ready = 4'hF;
        applyStimulus(1'b1, 8'h99, 2'd2, 1'b0);
        checkOutput("t6 resume ready", 32'(d4_ready), 32'h1);
        step();
        checkOutput("t6 resume valid", 32'(d4_valid), 32'h4);
        checkOutput("t6 resume data", 32'(d4_data[23:16]), 32'h99);
        applyStimulus(1'b0, 8'h00, 2'd0, 1'b0);
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
